// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the MAC tile scheduler: FSM state encoding,
// default widths/latencies and the drain-length helper.
package mac_sched_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int A_ADDR_W_DEF = 16;
  localparam int B_ADDR_W_DEF = 16;
  localparam int O_ADDR_W_DEF = 16;
  localparam int RD_LAT_DEF   = 2;
  localparam int MAC_LAT_DEF  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPUTE = 3'd1,
    S_DRAIN   = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  function automatic int drain_cyc(input int rd_lat, input int mac_lat);
    return rd_lat + mac_lat;
  endfunction

  localparam int DRAIN_CYC = RD_LAT_DEF + MAC_LAT_DEF;

endpackage

// File: rtl/mac_sched_delay.sv
// Fixed-depth shift line that re-times the read-issue strobe and first-beat
// flag so accumulate beats line up with buffer read data.
module mac_sched_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk_p,
  input  logic rst_n,
  input  logic flush_i,
  input  logic en_i,
  input  logic clr_i,
  output logic en_o,
  output logic clr_o
);

  logic [DEPTH-1:0] en_q;
  logic [DEPTH-1:0] clr_q;

  // Shift register; flush empties every stage so no stale beats escape an abort.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= {DEPTH{1'b0}};
      clr_q <= {DEPTH{1'b0}};
    end else if (flush_i) begin
      en_q  <= {DEPTH{1'b0}};
      clr_q <= {DEPTH{1'b0}};
    end else begin
      en_q[0]  <= en_i;
      clr_q[0] <= en_i & clr_i;
      for (int i = 1; i < DEPTH; i++) begin
        en_q[i]  <= en_q[i-1];
        clr_q[i] <= clr_q[i-1];
      end
    end
  end

  assign en_o  = en_q[DEPTH-1];
  assign clr_o = clr_q[DEPTH-1];

endmodule

// File: rtl/mac_tile_scheduler.sv
// Tile sequencer for the MAC engine: walks the M x N tile grid (n inner, m outer),
// streams K read beats per tile, waits out the pipeline, then offers the tile.
module mac_tile_scheduler
  import mac_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int A_ADDR_W = A_ADDR_W_DEF,
  parameter int B_ADDR_W = B_ADDR_W_DEF,
  parameter int O_ADDR_W = O_ADDR_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int MAC_LAT  = MAC_LAT_DEF
) (
  input  logic                clk_p,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [CNT_W-1:0]    cfg_m_tiles_i,
  input  logic [CNT_W-1:0]    cfg_n_tiles_i,
  input  logic [CNT_W-1:0]    cfg_k_tiles_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                a_rd_en_o,
  output logic [A_ADDR_W-1:0] a_rd_addr_o,
  output logic                b_rd_en_o,
  output logic [B_ADDR_W-1:0] b_rd_addr_o,
  output logic                bias_rd_en_o,
  output logic [CNT_W-1:0]    bias_rd_addr_o,
  output logic                acc_clr_o,
  output logic                acc_en_o,
  output logic                out_valid_o,
  output logic [O_ADDR_W-1:0] out_addr_o,
  input  logic                out_ready_i
);

  localparam int DRAIN_CYC_L = drain_cyc(RD_LAT, MAC_LAT);
  localparam int DRN_W       = $clog2(DRAIN_CYC_L + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cfg_m_q, cfg_m_d, cfg_n_q, cfg_n_d, cfg_k_q, cfg_k_d;
  logic [CNT_W-1:0]    m_q, m_d, n_q, n_d, k_q, k_d;
  logic [A_ADDR_W-1:0] a_base_q, a_base_d;
  logic [B_ADDR_W-1:0] b_base_q, b_base_d;
  logic [O_ADDR_W-1:0] o_base_q, o_base_d;
  logic [DRN_W-1:0]    drain_q, drain_d;

  logic issue_s, k_last_s, n_last_s, m_last_s, cfg_zero_s;

  assign issue_s    = (state_q == S_COMPUTE);
  assign k_last_s   = (k_q == cfg_k_q - CNT_W'(1));
  assign n_last_s   = (n_q == cfg_n_q - CNT_W'(1));
  assign m_last_s   = (m_q == cfg_m_q - CNT_W'(1));
  assign cfg_zero_s = (cfg_m_tiles_i == {CNT_W{1'b0}}) || (cfg_n_tiles_i == {CNT_W{1'b0}}) ||
                      (cfg_k_tiles_i == {CNT_W{1'b0}});

  // Next-state: abort overrides everything; base registers replace the m*K, k*N, m*N products.
  always_comb begin
    state_d  = state_q;
    cfg_m_d  = cfg_m_q;
    cfg_n_d  = cfg_n_q;
    cfg_k_d  = cfg_k_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    o_base_d = o_base_q;
    drain_d  = drain_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_m_d  = cfg_m_tiles_i;
            cfg_n_d  = cfg_n_tiles_i;
            cfg_k_d  = cfg_k_tiles_i;
            m_d      = {CNT_W{1'b0}};
            n_d      = {CNT_W{1'b0}};
            k_d      = {CNT_W{1'b0}};
            a_base_d = {A_ADDR_W{1'b0}};
            b_base_d = {B_ADDR_W{1'b0}};
            o_base_d = {O_ADDR_W{1'b0}};
            drain_d  = {DRN_W{1'b0}};
            state_d  = cfg_zero_s ? S_DONE : S_COMPUTE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_COMPUTE: begin
          if (k_last_s) begin
            drain_d = {DRN_W{1'b0}};
            state_d = S_DRAIN;
          end else begin
            k_d      = k_q + CNT_W'(1);
            b_base_d = b_base_q + B_ADDR_W'(cfg_n_q);
          end
        end
        S_DRAIN: begin
          if (drain_q == DRN_W'(DRAIN_CYC_L - 1)) begin
            state_d = S_WRITE;
          end else begin
            drain_d = drain_q + DRN_W'(1);
          end
        end
        S_WRITE: begin
          if (out_ready_i) begin
            k_d      = {CNT_W{1'b0}};
            b_base_d = {B_ADDR_W{1'b0}};
            if (n_last_s) begin
              n_d = {CNT_W{1'b0}};
              if (m_last_s) begin
                state_d = S_DONE;
              end else begin
                m_d      = m_q + CNT_W'(1);
                a_base_d = a_base_q + A_ADDR_W'(cfg_k_q);
                o_base_d = o_base_q + O_ADDR_W'(cfg_n_q);
                state_d  = S_COMPUTE;
              end
            end else begin
              n_d     = n_q + CNT_W'(1);
              state_d = S_COMPUTE;
            end
          end else begin
            state_d = S_WRITE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cfg_m_q  <= {CNT_W{1'b0}};
      cfg_n_q  <= {CNT_W{1'b0}};
      cfg_k_q  <= {CNT_W{1'b0}};
      m_q      <= {CNT_W{1'b0}};
      n_q      <= {CNT_W{1'b0}};
      k_q      <= {CNT_W{1'b0}};
      a_base_q <= {A_ADDR_W{1'b0}};
      b_base_q <= {B_ADDR_W{1'b0}};
      o_base_q <= {O_ADDR_W{1'b0}};
      drain_q  <= {DRN_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cfg_m_q  <= cfg_m_d;
      cfg_n_q  <= cfg_n_d;
      cfg_k_q  <= cfg_k_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      o_base_q <= o_base_d;
      drain_q  <= drain_d;
    end
  end

  // Outputs decode only registered state, so none has a combinational path from inputs.
  assign busy_o         = (state_q == S_COMPUTE) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done_o         = (state_q == S_DONE);
  assign a_rd_en_o      = issue_s;
  assign b_rd_en_o      = issue_s;
  assign a_rd_addr_o    = issue_s ? (a_base_q + A_ADDR_W'(k_q)) : {A_ADDR_W{1'b0}};
  assign b_rd_addr_o    = issue_s ? (b_base_q + B_ADDR_W'(n_q)) : {B_ADDR_W{1'b0}};
  assign bias_rd_en_o   = issue_s && k_last_s;
  assign bias_rd_addr_o = (issue_s && k_last_s) ? n_q : {CNT_W{1'b0}};
  assign out_valid_o    = (state_q == S_WRITE);
  assign out_addr_o     = (state_q == S_WRITE) ? (o_base_q + O_ADDR_W'(n_q)) : {O_ADDR_W{1'b0}};

  mac_sched_delay #(.DEPTH(RD_LAT)) u_delay (
    .clk_p   (clk_p),
    .rst_n   (rst_n),
    .flush_i (abort_i),
    .en_i    (issue_s),
    .clr_i   (k_q == {CNT_W{1'b0}}),
    .en_o    (acc_en_o),
    .clr_o   (acc_clr_o)
  );

endmodule
